// File: rtl/traffic_display_driver.sv
// traffic_display_driver
//   Consumer end of the light controller's display interface. On an update strobe it
//   captures both roads' remaining time and colour codes, converts each time to two BCD
//   digits with a 7-cycle shift-add-3 sequence, then commits digits and colours to the
//   display registers. A free-running scanner multiplexes four seven-segment digits
//   (main tens, main ones, sub tens, sub ones) and drives per-road lamps, including a
//   flashing-yellow ONLINE mode.
//
// Optional feature: define DISP_LAMP_TEST_EN to add lamp_test_i, which lights every
//   segment of the scanned digit and all lamps while high.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   main_time_i    main-road remaining seconds (binary)
//   sub_time_i     sub-road remaining seconds (binary)
//   main_color_i   main colour: 1=RED 2=GREEN 3=YELLOW 4=ONLINE, other=OFF
//   sub_color_i    sub colour, same encoding
//   update_i       one-cycle capture request, ignored while busy
//   lamp_test_i    (DISP_LAMP_TEST_EN only) force all segments and lamps on
//   busy_o         capture/convert in progress
//   seg_o          segments, active-low, {g,f,e,d,c,b,a}
//   dig_sel_o      digit enables, active-low one-hot, bit0 = main tens
//   main_lamp_o    {red,yellow,green}
//   sub_lamp_o     {red,yellow,green}
//   ovf_o          last captured time exceeded 99
module traffic_display_driver #(
  parameter int unsigned SCAN_DIV  = 4,
  parameter int unsigned BLINK_DIV = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] main_time_i,
  input  logic [15:0] sub_time_i,
  input  logic [7:0]  main_color_i,
  input  logic [7:0]  sub_color_i,
  input  logic        update_i,
`ifdef DISP_LAMP_TEST_EN
  input  logic        lamp_test_i,
`endif
  output logic        busy_o,
  output logic [6:0]  seg_o,
  output logic [3:0]  dig_sel_o,
  output logic [2:0]  main_lamp_o,
  output logic [2:0]  sub_lamp_o,
  output logic        ovf_o
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FrW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [7:0] ColRed    = 8'd1;
  localparam logic [7:0] ColGreen  = 8'd2;
  localparam logic [7:0] ColYellow = 8'd3;
  localparam logic [7:0] ColOnline = 8'd4;

  typedef enum logic [1:0] {StIdle, StConv, StCommit} state_e;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] sat99(input logic [15:0] t);
    return (t > 16'd99) ? 7'd99 : t[6:0];
  endfunction

  // One shift-add-3 step on {tens, ones, binary}. Values are <= 99, so the tens
  // nibble never carries out.
  function automatic logic [14:0] dd_step(input logic [14:0] v);
    logic [14:0] r;
    r = v;
    if (r[14:11] >= 4'd5) r[14:11] = r[14:11] + 4'd3;
    if (r[10:7]  >= 4'd5) r[10:7]  = r[10:7]  + 4'd3;
    return {r[13:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] lamp_of(input logic [7:0] col, input logic blink);
    logic [2:0] l;
    case (col)
      ColRed:    l = 3'b100;
      ColYellow: l = 3'b010;
      ColGreen:  l = 3'b001;
      ColOnline: l = {1'b0, blink, 1'b0};
      default:   l = 3'b000;
    endcase
    return l;
  endfunction

  // ---------------------------------------------------------------------------
  // Capture / convert FSM
  // ---------------------------------------------------------------------------
  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [14:0] main_sr_q, sub_sr_q;
  logic [7:0]  main_cap_col_q, sub_cap_col_q;
  logic        busy_q, ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      main_sr_q      <= '0;
      sub_sr_q       <= '0;
      main_cap_col_q <= '0;
      sub_cap_col_q  <= '0;
      busy_q         <= 1'b0;
      ovf_q          <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (update_i) begin
            main_sr_q      <= {8'd0, sat99(main_time_i)};
            sub_sr_q       <= {8'd0, sat99(sub_time_i)};
            main_cap_col_q <= main_color_i;
            sub_cap_col_q  <= sub_color_i;
            ovf_q          <= (main_time_i > 16'd99) || (sub_time_i > 16'd99);
            cnt_q          <= '0;
            busy_q         <= 1'b1;
            state_q        <= StConv;
          end
        end
        StConv: begin
          main_sr_q <= dd_step(main_sr_q);
          sub_sr_q  <= dd_step(sub_sr_q);
          cnt_q     <= cnt_q + 3'd1;
          if (cnt_q == 3'd6) state_q <= StCommit;
        end
        StCommit: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign ovf_o  = ovf_q;

  // ---------------------------------------------------------------------------
  // Display registers
  // ---------------------------------------------------------------------------
  logic [7:0] disp_main_q, disp_main_d, disp_sub_q, disp_sub_d;
  logic [7:0] disp_main_col_q, disp_main_col_d, disp_sub_col_q, disp_sub_col_d;
  logic       commit;

  assign commit = (state_q == StCommit);

  // Outputs decode from the next-state values so committed digits appear on seg the
  // cycle right after COMMIT.
  always_comb begin
    disp_main_d     = disp_main_q;
    disp_sub_d      = disp_sub_q;
    disp_main_col_d = disp_main_col_q;
    disp_sub_col_d  = disp_sub_col_q;
    if (commit) begin
      disp_main_d     = main_sr_q[14:7];
      disp_sub_d      = sub_sr_q[14:7];
      disp_main_col_d = main_cap_col_q;
      disp_sub_col_d  = sub_cap_col_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_main_q     <= '0;
      disp_sub_q      <= '0;
      disp_main_col_q <= '0;
      disp_sub_col_q  <= '0;
    end else begin
      disp_main_q     <= disp_main_d;
      disp_sub_q      <= disp_sub_d;
      disp_main_col_q <= disp_main_col_d;
      disp_sub_col_q  <= disp_sub_col_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan divider, digit index, frame counter and blink
  // ---------------------------------------------------------------------------
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      idx_q, idx_d;
  logic [FrW-1:0]  frame_q, frame_d;
  logic            blink_q, blink_d;

  always_comb begin
    div_d   = div_q + DivW'(1);
    idx_d   = idx_q;
    frame_d = frame_q;
    blink_d = blink_q;
    if (div_q == DivW'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        if (frame_q == FrW'(BLINK_DIV - 1)) begin
          frame_d = '0;
          blink_d = ~blink_q;
        end else begin
          frame_d = frame_q + FrW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  logic [6:0] seg_q, seg_d;
  logic [3:0] dig_sel_q, dig_sel_d;
  logic [2:0] main_lamp_q, main_lamp_d, sub_lamp_q, sub_lamp_d;
  logic       main_on, sub_on;
  logic [3:0] digit;
  logic       blank;

  always_comb begin
    main_on = disp_main_col_d inside {ColRed, ColGreen, ColYellow};
    sub_on  = disp_sub_col_d inside {ColRed, ColGreen, ColYellow};
    digit   = 4'd0;
    blank   = 1'b1;
    unique case (idx_d)
      2'd0: begin
        digit = disp_main_d[7:4];
        blank = !main_on || (disp_main_d[7:4] == 4'd0);
      end
      2'd1: begin
        digit = disp_main_d[3:0];
        blank = !main_on;
      end
      2'd2: begin
        digit = disp_sub_d[7:4];
        blank = !sub_on || (disp_sub_d[7:4] == 4'd0);
      end
      2'd3: begin
        digit = disp_sub_d[3:0];
        blank = !sub_on;
      end
    endcase
    seg_d       = blank ? 7'h7F : seg7(digit);
    dig_sel_d   = ~(4'b0001 << idx_d);
    main_lamp_d = lamp_of(disp_main_col_d, blink_d);
    sub_lamp_d  = lamp_of(disp_sub_col_d, blink_d);
`ifdef DISP_LAMP_TEST_EN
    if (lamp_test_i) begin
      seg_d       = 7'h00;
      main_lamp_d = 3'b111;
      sub_lamp_d  = 3'b111;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      idx_q       <= '0;
      frame_q     <= '0;
      blink_q     <= 1'b0;
      seg_q       <= 7'h7F;
      dig_sel_q   <= 4'hF;
      main_lamp_q <= 3'b000;
      sub_lamp_q  <= 3'b000;
    end else begin
      div_q       <= div_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      blink_q     <= blink_d;
      seg_q       <= seg_d;
      dig_sel_q   <= dig_sel_d;
      main_lamp_q <= main_lamp_d;
      sub_lamp_q  <= sub_lamp_d;
    end
  end

  assign seg_o       = seg_q;
  assign dig_sel_o   = dig_sel_q;
  assign main_lamp_o = main_lamp_q;
  assign sub_lamp_o  = sub_lamp_q;

endmodule
